l0_ctrl: RTL and testbench
==========================

Name: l0_ctrl

Overview:
- Sequencer for the L0 row-input FIFO bank that feeds the systolic MAC array.
- On a start pulse it streams NUM_VEC activation vectors from activation SRAM into L0, then drains them into the array.
- Fill and drain run in parallel. Drain is gated by array back-pressure.
- After the last read, it waits for the L0 cascade row skew to flush, then pulses done.

Parameters:
- row, 8, number of L0 rows / array rows. This is also the cascade skew length in cycles.
- bw, 4, bits per row element. L0 word is row*bw bits; the controller does not touch data.
- depth, 64, L0 FIFO depth in vectors.
- addr_w, 11, SRAM address width.
- cnt_w, 8, vector-count width (max 255 vectors per job).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start pulse; ignored unless idle.
- num_vec  in  cnt_w  vectors in job; sampled with start.
- base_addr  in  addr_w  first SRAM address; sampled with start.
- array_en  in  1  array can accept a vector this cycle.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_wen  out  1  SRAM write enable, active low; tied 1 (read-only).
- sram_addr  out  addr_w  SRAM read address.
- l0_wr  out  1  L0 write strobe.
- l0_rd  out  1  L0 read strobe.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset (at any time, including mid-job):
  - state becomes IDLE and all counters clear.
  - sram_cen=1, sram_wen=1, sram_addr=0, l0_wr=0, l0_rd=0, busy=0, done=0.
  - Any in-flight SRAM read is discarded (no l0_wr follows).
- States: IDLE, RUN, FLUSH, DONE. Outputs are decoded from registered state and counters.
- IDLE:
  - start=1 with num_vec>0: latch num_vec and base_addr, clear issued/written/drained, go to RUN.
  - start=1 with num_vec=0: go directly to DONE.
- RUN, issue engine:
  - Issue a read when issued<num_vec and (issued-drained)<depth.
  - On issue: sram_cen=0, sram_addr=base+issued (wraps mod 2^addr_w), issued increments.
  - The occupancy count includes in-flight reads, so L0 never overflows.
- RUN, write path:
  - SRAM read latency is 1 cycle: l0_wr=1 exactly one cycle after each issue.
  - written increments on each l0_wr.
- RUN, drain engine:
  - l0_rd=1 when written>drained and array_en=1; drained increments on each l0_rd.
  - Data written on cycle n is readable no earlier than cycle n+1.
  - array_en=0 holds drain only; issue continues until the depth limit.
- RUN to FLUSH: on the edge where drained reaches num_vec.
- FLUSH:
  - Lasts exactly row cycles, counted by a skew counter.
  - No SRAM or L0 activity.
  - Then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy or in DONE: ignored; latched values are unchanged.
- Counters are cnt_w+1 bits wide internally, so that compares at num_vec=255 never wrap.

Optional Feature:
- Macro: L0_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Counts RUN cycles where written>drained but array_en=0.
  - Saturates at 0xFFFF, clears on reset and on accepted start, holds after done.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-job: reset=1 for 1 cycle during RUN. Required: next cycle IDLE, all outputs at reset values, no further l0_wr.
- Basic job: num_vec=4, base=0x010, array_en=1. Required:
  - sram_cen=0 at cycles 1-4 with addresses 0x010-0x013.
  - l0_wr at cycles 2-5; l0_rd at cycles 3-6.
  - FLUSH at cycles 7-14; done at cycle 15; busy high for cycles 1-14.
- Back-pressure: num_vec=80, depth=64, array_en=0 until cycle 100. Required:
  - Exactly 64 issues, then issue stalls.
  - After array_en rises, 80 total l0_rd; done follows.
  - With the macro defined: stall_cnt equals the number of cycles with written>drained and array_en=0.
- Edge cases:
  - num_vec=0: done pulses the cycle after start, with no SRAM access.
  - base=0x7FE, num_vec=3: addresses are 0x7FE, 0x7FF, 0x000.
- Start while busy: a second start at cycle 3 with num_vec=9. Required: ignored; job finishes with 4 reads; exactly one done pulse.

Source files
------------

// File: rtl/l0_ctrl_if.sv
// Control-side bus of the L0 sequencer: job request, SRAM read port, L0 strobes and status.
interface l0_ctrl_if #(
  parameter int addr_w = 11,
  parameter int cnt_w  = 8
);
  logic              start;
  logic [cnt_w-1:0]  num_vec;
  logic [addr_w-1:0] base_addr;
  logic              array_en;
  logic              sram_cen;
  logic              sram_wen;
  logic [addr_w-1:0] sram_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic              busy;
  logic              done;

  modport master (
    input  start, num_vec, base_addr, array_en,
    output sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, busy, done
  );

  modport slave (
    output start, num_vec, base_addr, array_en,
    input  sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, busy, done
  );
endinterface

// File: rtl/l0_ctrl.sv
// L0 row-input FIFO sequencer: streams activation vectors SRAM->L0->array, then waits out the row skew.
// Optional macro L0_CTRL_STALL_CNT_EN adds a 16-bit back-pressure stall counter output.
module l0_ctrl #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int depth  = 64,
  parameter int addr_w = 11,
  parameter int cnt_w  = 8
) (
  input  logic         clk,
  input  logic         reset,
  l0_ctrl_if.master    bus
`ifdef L0_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int skew_w = $clog2(row) + 1;
  localparam logic [cnt_w:0]    depth_c   = (cnt_w + 1)'(depth);
  localparam logic [cnt_w:0]    one_c     = (cnt_w + 1)'(1);
  localparam logic [skew_w-1:0] skew_last = skew_w'(row - 1);

  // Occupancy is compared in cnt_w+1 bits, so depth must fit there.
  if (row < 1 || bw < 1 || depth < 1 || depth > (2 ** cnt_w)) begin : g_param_check
    $error("l0_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [cnt_w:0]      num_r, issued_r, written_r, drained_r;
  logic [cnt_w:0]      occ_s;
  logic [addr_w-1:0]   base_r;
  logic [skew_w-1:0]   skew_r;
  logic                wr_pend_r;
  logic                issue_s, drain_s, accept_s;

  // Occupancy counts in-flight reads too, so L0 can never overflow.
  assign occ_s = issued_r - drained_r;

  // Next-state and issue/drain decode from registered state and counters.
  always_comb begin
    state_s  = state_r;
    issue_s  = 1'b0;
    drain_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (bus.num_vec != {cnt_w{1'b0}}) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        issue_s = (issued_r < num_r) && (occ_s < depth_c);
        drain_s = (written_r > drained_r) && bus.array_en;
        if (drain_s && ((drained_r + one_c) == num_r)) begin
          state_s = FLUSH;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (skew_r == skew_last) begin
          state_s = DONE;
        end else begin
          state_s = FLUSH;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job registers, progress counters, read-latency pipe and flush skew counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_r     <= {(cnt_w + 1){1'b0}};
      base_r    <= {addr_w{1'b0}};
      issued_r  <= {(cnt_w + 1){1'b0}};
      written_r <= {(cnt_w + 1){1'b0}};
      drained_r <= {(cnt_w + 1){1'b0}};
      wr_pend_r <= 1'b0;
      skew_r    <= {skew_w{1'b0}};
    end else begin
      wr_pend_r <= issue_s;
      if (accept_s) begin
        num_r     <= {1'b0, bus.num_vec};
        base_r    <= bus.base_addr;
        issued_r  <= {(cnt_w + 1){1'b0}};
        written_r <= {(cnt_w + 1){1'b0}};
        drained_r <= {(cnt_w + 1){1'b0}};
      end else begin
        if (issue_s)   issued_r  <= issued_r + one_c;
        if (wr_pend_r) written_r <= written_r + one_c;
        if (drain_s)   drained_r <= drained_r + one_c;
      end
      if (state_r == FLUSH) begin
        skew_r <= skew_r + skew_w'(1);
      end else begin
        skew_r <= {skew_w{1'b0}};
      end
    end
  end

  assign bus.sram_cen  = ~issue_s;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = issue_s ? (base_r + addr_w'(issued_r)) : {addr_w{1'b0}};
  assign bus.l0_wr     = wr_pend_r;
  assign bus.l0_rd     = drain_s;
  assign bus.busy      = (state_r == RUN) || (state_r == FLUSH);
  assign bus.done      = (state_r == DONE);

`ifdef L0_CTRL_STALL_CNT_EN
  logic [15:0] stall_r;

  // Saturating count of RUN cycles where L0 holds data but the array refuses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r <= 16'h0000;
    end else if (accept_s) begin
      stall_r <= 16'h0000;
    end else if ((state_r == RUN) && (written_r > drained_r) && !bus.array_en
                 && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'h0001;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_l0_ctrl.sv
// Scoreboard bench for l0_ctrl: stimulus pushes expected SRAM/L0/done events, a negedge monitor pops and checks.
module tb_l0_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l0_ctrl_if #(.addr_w(11), .cnt_w(8)) bus ();
`ifdef L0_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  l0_ctrl #(.row(8), .bw(4), .depth(64), .addr_w(11), .cnt_w(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef L0_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    int          c;
    logic [10:0] a;
  } iss_t;

  int   cyc = 0;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   job_active = 1'b0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  iss_t exp_iss[$];
  int   exp_wr[$];
  int   exp_rd[$];
  int   exp_done[$];
  iss_t e;
  int   rel;
  int   ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (job cycle %0d)", name, got, want, cyc - t0);
    end
  endtask

  task automatic unexpected(input string name, input int at);
    tests++;
    fails++;
    $display("FAIL %s: event at job cycle %0d, none expected", name, at);
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - t0;
      if (bus.sram_cen === 1'b0) begin
        if (exp_iss.size() == 0) unexpected("issue", rel);
        else begin
          e = exp_iss.pop_front();
          check("issue_cycle", rel, e.c);
          check("issue_addr", int'(bus.sram_addr), int'(e.a));
        end
      end
      if (bus.l0_wr === 1'b1) begin
        if (exp_wr.size() == 0) unexpected("l0_wr", rel);
        else begin ev = exp_wr.pop_front(); check("l0_wr_cycle", rel, ev); end
      end
      if (bus.l0_rd === 1'b1) begin
        if (exp_rd.size() == 0) unexpected("l0_rd", rel);
        else begin ev = exp_rd.pop_front(); check("l0_rd_cycle", rel, ev); end
      end
      if (bus.done === 1'b1) begin
        if (exp_done.size() == 0) unexpected("done", rel);
        else begin ev = exp_done.pop_front(); check("done_cycle", rel, ev); end
      end
      if (job_active) begin
        check("busy", int'(bus.busy), int'(rel >= busy_lo && rel <= busy_hi));
        check("sram_wen", int'(bus.sram_wen), 1);
      end
    end
  end

  task automatic push_issue(input int c, input logic [10:0] a);
    iss_t x;
    x.c = c;
    x.a = a;
    exp_iss.push_back(x);
    exp_wr.push_back(c + 1);
  endtask

  // Unstalled job of n>0 vectors: one issue per cycle, flush of 8, done at n+11.
  task automatic push_simple(input int n, input logic [10:0] base);
    for (int i = 0; i < n; i++) begin
      push_issue(i + 1, 11'(base + 11'(i)));
      exp_rd.push_back(i + 3);
    end
    exp_done.push_back(n + 11);
    busy_lo = 1;
    busy_hi = n + 10;
  endtask

  task automatic start_job(input int n, input logic [10:0] base, input logic ae);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.num_vec   = 8'(n);
    bus.base_addr = base;
    bus.array_en  = ae;
    t0 = cyc;
    job_active = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_rel(input int target);
    while (cyc - t0 < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_job(input int last, input string tag);
    wait_rel(last + 3);
    check({tag, "_left_issue"}, exp_iss.size(), 0);
    check({tag, "_left_wr"}, exp_wr.size(), 0);
    check({tag, "_left_rd"}, exp_rd.size(), 0);
    check({tag, "_left_done"}, exp_done.size(), 0);
    job_active = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cen"}, int'(bus.sram_cen), 1);
    check({tag, "_wen"}, int'(bus.sram_wen), 1);
    check({tag, "_addr"}, int'(bus.sram_addr), 0);
    check({tag, "_l0_wr"}, int'(bus.l0_wr), 0);
    check({tag, "_l0_rd"}, int'(bus.l0_rd), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_vec = 8'd0;
    bus.base_addr = 11'd0;
    bus.array_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic job.
    push_simple(4, 11'h010);
    start_job(4, 11'h010, 1'b1);
    finish_job(15, "basic");

    // Second start at cycle 3 must be ignored.
    push_simple(4, 11'h020);
    start_job(4, 11'h020, 1'b1);
    wait_rel(3);
    bus.start = 1'b1;
    bus.num_vec = 8'd9;
    bus.base_addr = 11'h100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_job(15, "busy_start");

    // Empty job: done on the next cycle, no SRAM access.
    exp_done.push_back(1);
    busy_lo = 1;
    busy_hi = 0;
    start_job(0, 11'h055, 1'b1);
    finish_job(1, "zero");

    // Address wrap at the top of the SRAM.
    push_simple(3, 11'h7FE);
    start_job(3, 11'h7FE, 1'b1);
    finish_job(14, "wrap");

    // Back-pressure: 64 issues fill L0, then one issue per drained vector.
    for (int i = 0; i < 80; i++) begin
      push_issue((i < 64) ? (i + 1) : (101 + i - 64), 11'(11'h100 + 11'(i)));
      exp_rd.push_back(100 + i);
    end
    exp_done.push_back(188);
    busy_lo = 1;
    busy_hi = 187;
    start_job(80, 11'h100, 1'b0);
    wait_rel(100);
    bus.array_en = 1'b1;
    finish_job(188, "backpressure");
`ifdef L0_CTRL_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), 97);
`endif

    // Reset mid-job: the read issued in the reset cycle never reaches L0.
    push_issue(1, 11'h200);
    push_issue(2, 11'h201);
    push_issue(3, 11'h202);
    void'(exp_wr.pop_back());
    exp_rd.push_back(3);
    busy_lo = 1;
    busy_hi = 3;
    start_job(10, 11'h200, 1'b1);
    wait_rel(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    finish_job(12, "midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
